// File: rtl/register_dumper_pkg.sv
// Shared types and constants for the register-file dump engine.
package register_dumper_pkg;

    localparam int DefaultDataBitWidth = 32;
    localparam int BytesPerWord        = DefaultDataBitWidth / 8;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_SEND,
        ST_DONE
    } state_t;

endpackage

// File: rtl/register_dumper.sv
// Walks the register file's spare read port and streams every register as
// bytes, most significant byte first, over a valid/ready byte interface.
//
// state   | meaning
// --------+-----------------------------------------------------------
// ST_IDLE | waiting for start; no byte offered
// ST_LOAD | capture reg_data for the current reg_addr
// ST_SEND | offer the top byte of the shift register until accepted
// ST_DONE | one-cycle done pulse, then back to idle
module register_dumper
    import register_dumper_pkg::*;
#(
    parameter int AddressBitWidth = 5,
    parameter int DataBitWidth    = 32
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       start,
    output logic                       busy,
    output logic                       done,
    output logic [AddressBitWidth-1:0] reg_addr,
    input  logic [DataBitWidth-1:0]    reg_data,
    output logic [7:0]                 byte_data,
    output logic                       byte_valid,
    input  logic                       byte_ready
);

    localparam int WordBytes = DataBitWidth / 8;
    localparam int IdxWidth  = (WordBytes > 1) ? $clog2(WordBytes) : 1;

    localparam logic [IdxWidth-1:0]        LastIdx  = IdxWidth'(WordBytes - 1);
    localparam logic [AddressBitWidth-1:0] LastAddr = '1;

    if (DataBitWidth % 8 != 0) begin : g_width_check
        $error("register_dumper: DataBitWidth must be a multiple of 8");
    end

    state_t                  state;
    logic [DataBitWidth-1:0] shift_reg;
    logic [IdxWidth-1:0]     byte_idx;

    // The outgoing byte is always the top of the shift register, so it
    // stays stable for as long as the sink stalls.
    assign byte_data = shift_reg[DataBitWidth-1 -: 8];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            busy       <= 1'b0;
            done       <= 1'b0;
            reg_addr   <= '0;
            byte_valid <= 1'b0;
            shift_reg  <= '0;
            byte_idx   <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        reg_addr <= '0;
                        busy     <= 1'b1;
                        state    <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    shift_reg  <= reg_data;
                    byte_idx   <= '0;
                    byte_valid <= 1'b1;
                    state      <= ST_SEND;
                end
                ST_SEND: begin
                    if (byte_ready) begin
                        if (byte_idx != LastIdx) begin
                            shift_reg <= shift_reg << 8;
                            byte_idx  <= byte_idx + IdxWidth'(1);
                        end else begin
                            byte_valid <= 1'b0;
                            if (reg_addr != LastAddr) begin
                                reg_addr <= reg_addr + AddressBitWidth'(1);
                                state    <= ST_LOAD;
                            end else begin
                                done  <= 1'b1;
                                state <= ST_DONE;
                            end
                        end
                    end
                end
                ST_DONE: begin
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_register_dumper.sv
// Bench for register_dumper: register-file model, byte scoreboard, scenario
// table for full dumps and hand-written reset/restart/write-during-dump cases.
module tb_register_dumper;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        busy;
    logic        done;
    logic [4:0]  reg_addr;
    logic [31:0] reg_data;
    logic [7:0]  byte_data;
    logic        byte_valid;
    logic        byte_ready = 1'b0;

    logic [31:0] regs [32];
    logic [7:0]  exp_q [$];

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    int done_cnt = 0;
    int done_cyc = 0;
    int byte_cnt = 0;
    bit hold = 1'b0;
    logic [7:0] hold_byte = 8'h00;

    register_dumper dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .busy       (busy),
        .done       (done),
        .reg_addr   (reg_addr),
        .reg_data   (reg_data),
        .byte_data  (byte_data),
        .byte_valid (byte_valid),
        .byte_ready (byte_ready)
    );

    assign reg_data = regs[reg_addr];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Byte monitor: the handshake completes at the next rising edge.
    always @(negedge clk) begin
        if (!rst_n) begin
            hold = 1'b0;
        end else begin
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
            end
            if (hold) begin
                check("valid_held", {31'd0, byte_valid}, 32'd1);
                check("data_held", {24'd0, byte_data}, {24'd0, hold_byte});
            end
            hold = 1'b0;
            if (byte_valid) begin
                if (byte_ready) begin
                    byte_cnt++;
                    if (exp_q.size() == 0)
                        check("extra_byte", {24'd0, byte_data}, 32'hFFFF_FFFF);
                    else
                        check("byte", {24'd0, byte_data}, {24'd0, exp_q.pop_front()});
                end else begin
                    hold = 1'b1;
                    hold_byte = byte_data;
                end
            end
        end
    end

    task automatic push_dump(input int alt_idx, input logic [31:0] alt_val);
        logic [31:0] w;
        for (int i = 0; i < 32; i++) begin
            w = (i == alt_idx) ? alt_val : regs[i];
            for (int b = 3; b >= 0; b--) exp_q.push_back(w[8*b +: 8]);
        end
    endtask

    // Runs one dump; optionally writes regs[wr_idx] once reg_addr reaches wr_at.
    task automatic run_dump(input string nm, input int pct, input bit repulse,
                            input int exp_cycles, input int exp_bytes, input int exp_dones,
                            input int wr_at, input int wr_idx, input logic [31:0] wr_val);
        int d0, c0;
        bit seen, written;
        d0 = done_cnt;
        byte_cnt = 0;
        seen = 1'b0;
        written = 1'b0;
        @(posedge clk); #1;
        c0 = cyc;
        start = 1'b1;
        byte_ready = ($urandom_range(99, 0) < pct);
        for (int k = 0; k < 4000 && !seen; k++) begin
            @(posedge clk); #1;
            start = (repulse && (k == 40 || k == 41 || k == 90)) ? 1'b1 : 1'b0;
            byte_ready = ($urandom_range(99, 0) < pct);
            if (k == 0) begin
                check({nm, "_busy_on"}, {31'd0, busy}, 32'd1);
                check({nm, "_load_novalid"}, {31'd0, byte_valid}, 32'd0);
            end
            if (k == 1) check({nm, "_first_valid"}, {31'd0, byte_valid}, 32'd1);
            if (!written && wr_at >= 0 && int'(reg_addr) == wr_at) begin
                regs[wr_idx] = wr_val;
                written = 1'b1;
            end
            if (done_cnt != d0) seen = 1'b1;
        end
        if (!seen) check({nm, "_done_timeout"}, 32'd0, 32'd1);
        @(posedge clk); #1;
        check({nm, "_busy_after"}, {30'd0, busy, done}, 32'd0);
        repeat (5) @(posedge clk);
        #1;
        check({nm, "_dones"}, done_cnt - d0, exp_dones);
        check({nm, "_bytes"}, byte_cnt, exp_bytes);
        check({nm, "_drained"}, exp_q.size(), 32'd0);
        if (exp_cycles >= 0) check({nm, "_done_cycle"}, done_cyc - c0, exp_cycles);
        byte_ready = 1'b0;
    endtask

    typedef struct {
        string nm;
        int    ready_pct;
        bit    repulse;
        int    exp_cycles;
        int    exp_bytes;
        int    exp_dones;
    } vec_t;

    vec_t vecs [4];

    initial begin
        int d0;
        bit found;

        vecs[0] = '{"full", 100, 1'b0, 161, 128, 1};
        vecs[1] = '{"bp50", 50, 1'b0, -1, 128, 1};
        vecs[2] = '{"repulse", 100, 1'b1, 161, 128, 1};
        vecs[3] = '{"bp30_repulse", 30, 1'b1, -1, 128, 1};

        regs[0] = 32'h0;
        for (int i = 1; i < 32; i++) regs[i] = 32'h1000_0000 + i;

        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            check("idle_outputs", {busy, done, byte_valid, reg_addr, byte_data}, 32'd0);
        end

        for (int v = 0; v < 4; v++) begin
            push_dump(-1, 32'h0);
            run_dump(vecs[v].nm, vecs[v].ready_pct, vecs[v].repulse, vecs[v].exp_cycles,
                     vecs[v].exp_bytes, vecs[v].exp_dones, -1, 0, 32'h0);
        end

        // start held through Done restarts on the first Idle cycle
        push_dump(-1, 32'h0);
        push_dump(-1, 32'h0);
        d0 = done_cnt;
        byte_cnt = 0;
        @(posedge clk); #1;
        start = 1'b1;
        byte_ready = 1'b1;
        found = 1'b0;
        for (int k = 0; k < 400 && !found; k++) begin
            @(posedge clk); #1;
            if (done) found = 1'b1;
        end
        check("held_first_done", {31'd0, found}, 32'd1);
        @(posedge clk); #1;
        check("held_idle_gap", {30'd0, busy, done}, 32'd0);
        @(posedge clk); #1;
        check("held_restart_busy", {31'd0, busy}, 32'd1);
        start = 1'b0;
        found = 1'b0;
        for (int k = 0; k < 400 && !found; k++) begin
            @(posedge clk); #1;
            if (done) found = 1'b1;
        end
        repeat (3) @(posedge clk);
        #1;
        check("held_dones", done_cnt - d0, 32'd2);
        check("held_bytes", byte_cnt, 32'd256);
        check("held_drained", exp_q.size(), 32'd0);

        // reset while sending register 7
        push_dump(-1, 32'h0);
        d0 = done_cnt;
        @(posedge clk); #1;
        start = 1'b1;
        byte_ready = 1'b1;
        found = 1'b0;
        for (int k = 0; k < 400 && !found; k++) begin
            @(posedge clk); #1;
            start = 1'b0;
            if (reg_addr == 5'd7 && byte_valid) found = 1'b1;
        end
        check("rst_reach_reg7", {31'd0, found}, 32'd1);
        rst_n = 1'b0;
        byte_ready = 1'b0;
        @(posedge clk); #1;
        check("rst_outputs", {busy, done, byte_valid, reg_addr, byte_data}, 32'd0);
        rst_n = 1'b1;
        exp_q.delete();
        byte_ready = 1'b1;
        for (int k = 0; k < 20; k++) begin
            @(posedge clk); #1;
            check("rst_quiet", {30'd0, byte_valid, busy}, 32'd0);
        end
        check("rst_no_done", done_cnt - d0, 32'd0);
        push_dump(-1, 32'h0);
        run_dump("after_rst", 100, 1'b0, 161, 128, 1, -1, 0, 32'h0);

        // core write to x5 while dumping x2 is seen in the dump
        push_dump(5, 32'hDEAD_BEEF);
        run_dump("wr_x5", 100, 1'b0, 161, 128, 1, 2, 5, 32'hDEAD_BEEF);
        check("x5_model", regs[5], 32'hDEAD_BEEF);

        // write to x1 after it was loaded keeps the old value in the dump
        push_dump(1, 32'h1000_0001);
        regs[1] = 32'h1000_0001;
        run_dump("wr_x1_late", 60, 1'b0, -1, 128, 1, 2, 1, 32'hCAFE_F00D);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
